// File: rtl/pcs_sync_fsm_if.sv
// Code-group stream into the sync FSM and its registered pass-through copy.
// master = decoder side, slave = sync FSM side.
interface pcs_sync_fsm_if;
  logic       cg_valid;
  logic [9:0] cg_in;
  logic [7:0] data_in;
  logic       is_control_in;
  logic       decode_error;
  logic       disparity_error;
  logic       out_valid;
  logic [7:0] data_out;
  logic       is_control_out;

  modport master (
    output cg_valid, cg_in, data_in, is_control_in, decode_error, disparity_error,
    input  out_valid, data_out, is_control_out
  );

  modport slave (
    input  cg_valid, cg_in, data_in, is_control_in, decode_error, disparity_error,
    output out_valid, data_out, is_control_out
  );
endinterface

// File: rtl/pcs_sync_fsm.sv
// 1000BASE-X PCS receive synchronization FSM with registered data pass-through.
// All outputs registered, 1-cycle latency; no backpressure, cg_valid = 0 simply freezes the FSM.
module pcs_sync_fsm #(
  parameter bit SIGNAL_DETECT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcs_sync_fsm_if.slave        io,
  input  logic                 signal_detect,
  output logic                 sync_status,
  output logic                 rx_even,
  output logic [3:0]           sync_state,
  output logic                 lost_sync
);

  typedef enum logic [3:0] {
    LOSS_OF_SYNC = 4'd0,
    CD1          = 4'd1,
    AS1          = 4'd2,
    CD2          = 4'd3,
    AS2          = 4'd4,
    CD3          = 4'd5,
    SA1          = 4'd6,
    SA2          = 4'd7,
    SA2A         = 4'd8,
    SA3          = 4'd9,
    SA3A         = 4'd10,
    SA4          = 4'd11,
    SA4A         = 4'd12
  } state_e;

  state_e     state_q, state_d;
  logic       rx_even_q, rx_even_d;
  logic [1:0] good_cnt_q, good_cnt_d;
  logic       sync_status_q, sync_status_d;
  logic       lost_sync_q, lost_sync_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       is_control_out_q, is_control_out_d;

  logic comma, invalid, cgbad, isdata;
  logic unused_cg_low;

  // Comma detection only needs the 7-bit comma window.
  assign unused_cg_low = ^io.cg_in[2:0];

  always_comb begin
    comma   = (io.cg_in[9:3] == 7'b0011111) || (io.cg_in[9:3] == 7'b1100000);
    invalid = io.decode_error | io.disparity_error;
    cgbad   = invalid | (comma & rx_even_q);
    isdata  = ~invalid & ~io.is_control_in;

    state_d    = state_q;
    rx_even_d  = rx_even_q;
    good_cnt_d = good_cnt_q;

    if (SIGNAL_DETECT_EN && !signal_detect) begin
      state_d = LOSS_OF_SYNC;
      if (io.cg_valid) rx_even_d = ~rx_even_q;
    end else if (io.cg_valid) begin
      rx_even_d = ~rx_even_q;
      case (state_q)
        LOSS_OF_SYNC: if (comma) begin state_d = CD1; rx_even_d = 1'b1; end
        CD1: state_d = isdata ? AS1 : LOSS_OF_SYNC;
        CD2: state_d = isdata ? AS2 : LOSS_OF_SYNC;
        CD3: state_d = isdata ? SA1 : LOSS_OF_SYNC;
        AS1: begin
          if (cgbad) state_d = LOSS_OF_SYNC;
          else if (comma && !rx_even_q) begin state_d = CD2; rx_even_d = 1'b1; end
        end
        AS2: begin
          if (cgbad) state_d = LOSS_OF_SYNC;
          else if (comma && !rx_even_q) begin state_d = CD3; rx_even_d = 1'b1; end
        end
        SA1: if (cgbad) begin state_d = SA2; good_cnt_d = 2'd0; end
        SA2: begin
          if (cgbad) begin state_d = SA3; good_cnt_d = 2'd0; end
          else       begin state_d = SA2A; good_cnt_d = 2'd1; end
        end
        SA3: begin
          if (cgbad) begin state_d = SA4; good_cnt_d = 2'd0; end
          else       begin state_d = SA3A; good_cnt_d = 2'd1; end
        end
        SA4: begin
          if (cgbad) state_d = LOSS_OF_SYNC;
          else       begin state_d = SA4A; good_cnt_d = 2'd1; end
        end
        // Fourth consecutive good code-group in an A state steps back one level.
        SA2A: begin
          if (cgbad)                    begin state_d = SA3; good_cnt_d = 2'd0; end
          else if (good_cnt_q == 2'd3)  state_d = SA1;
          else                          good_cnt_d = good_cnt_q + 2'd1;
        end
        SA3A: begin
          if (cgbad)                    begin state_d = SA4; good_cnt_d = 2'd0; end
          else if (good_cnt_q == 2'd3)  begin state_d = SA2; good_cnt_d = 2'd0; end
          else                          good_cnt_d = good_cnt_q + 2'd1;
        end
        SA4A: begin
          if (cgbad)                    state_d = LOSS_OF_SYNC;
          else if (good_cnt_q == 2'd3)  begin state_d = SA3; good_cnt_d = 2'd0; end
          else                          good_cnt_d = good_cnt_q + 2'd1;
        end
        default: state_d = LOSS_OF_SYNC;
      endcase
    end else if (state_q > SA4A) begin
      state_d = LOSS_OF_SYNC;
    end

    sync_status_d    = (state_d >= SA1) && (state_d <= SA4A);
    lost_sync_d      = sync_status_q & ~sync_status_d;
    out_valid_d      = io.cg_valid;
    data_out_d       = io.data_in;
    is_control_out_d = io.is_control_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= LOSS_OF_SYNC;
      rx_even_q        <= 1'b0;
      good_cnt_q       <= 2'd0;
      sync_status_q    <= 1'b0;
      lost_sync_q      <= 1'b0;
      out_valid_q      <= 1'b0;
      data_out_q       <= 8'h00;
      is_control_out_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      rx_even_q        <= rx_even_d;
      good_cnt_q       <= good_cnt_d;
      sync_status_q    <= sync_status_d;
      lost_sync_q      <= lost_sync_d;
      out_valid_q      <= out_valid_d;
      data_out_q       <= data_out_d;
      is_control_out_q <= is_control_out_d;
    end
  end

  assign sync_state        = state_q;
  assign sync_status       = sync_status_q;
  assign rx_even           = rx_even_q;
  assign lost_sync         = lost_sync_q;
  assign io.out_valid      = out_valid_q;
  assign io.data_out       = data_out_q;
  assign io.is_control_out = is_control_out_q;

endmodule

// File: tb/tb_pcs_sync_fsm.sv
// Bench for pcs_sync_fsm: directed scenarios plus random traffic against a level-based model,
// two instances (signal_detect honoured / ignored) driven with identical code-groups.
module tb_pcs_sync_fsm;

  localparam logic [9:0] K_N = 10'b0011111010;
  localparam logic [9:0] K_P = 10'b1100000101;
  localparam logic [9:0] D_P = 10'b1001000101;
  localparam logic [9:0] K23 = 10'b1110101000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sd = 1'b1;
  int   checks = 0;
  int   failures = 0;

  pcs_sync_fsm_if bus1();
  pcs_sync_fsm_if bus0();

  logic [3:0] st1, st0;
  logic       ss1, re1, ls1, ss0, re0, ls0;

  pcs_sync_fsm #(.SIGNAL_DETECT_EN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .io(bus1), .signal_detect(sd),
    .sync_status(ss1), .rx_even(re1), .sync_state(st1), .lost_sync(ls1)
  );

  pcs_sync_fsm #(.SIGNAL_DETECT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .io(bus0), .signal_detect(sd),
    .sync_status(ss0), .rx_even(re0), .sync_state(st0), .lost_sync(ls0)
  );

  always #5 clk = ~clk;

  // Model: acquisition level (commas seen) or sync tier (1..4) with a run of good groups.
  typedef struct packed {
    logic       sync;
    logic [1:0] acq;
    logic       cd;
    logic [2:0] tier;
    logic [2:0] good;
    logic       even;
    logic       lost;
    logic       ov;
    logic [7:0] dat;
    logic       ctl;
  } model_t;

  model_t m1 = '0;
  model_t m0 = '0;

  function automatic model_t step(input model_t m, input bit en, input logic v,
                                  input logic [9:0] cg, input logic [7:0] d, input logic k,
                                  input logic de, input logic pe, input logic sdet);
    model_t n;
    logic [6:0] win;
    bit comma, inv, bad, isd;
    n = m;
    win = cg[9:3];
    comma = (win == 7'b0011111) || (win == 7'b1100000);
    inv = de | pe;
    bad = inv | (comma & m.even);
    isd = !inv && !k;
    n.ov = v; n.dat = d; n.ctl = k;
    if (v) n.even = !m.even;
    if (en && !sdet) begin
      n.sync = 1'b0; n.acq = 2'd0; n.cd = 1'b0;
    end else if (v) begin
      if (!m.sync) begin
        if (m.acq == 2'd0) begin
          if (comma) begin n.acq = 2'd1; n.cd = 1'b1; n.even = 1'b1; end
        end else if (m.cd) begin
          if (!isd) begin n.acq = 2'd0; n.cd = 1'b0; end
          else if (m.acq == 2'd3) begin
            n.sync = 1'b1; n.tier = 3'd1; n.good = 3'd0; n.acq = 2'd0; n.cd = 1'b0;
          end else n.cd = 1'b0;
        end else begin
          if (bad) n.acq = 2'd0;
          else if (comma && !m.even) begin n.acq = m.acq + 2'd1; n.cd = 1'b1; n.even = 1'b1; end
        end
      end else begin
        if (bad) begin
          if (m.tier == 3'd4) begin n.sync = 1'b0; n.acq = 2'd0; n.cd = 1'b0; end
          else begin n.tier = m.tier + 3'd1; n.good = 3'd0; end
        end else if (m.tier != 3'd1) begin
          n.good = m.good + 3'd1;
          if (n.good == 3'd4) begin n.tier = m.tier - 3'd1; n.good = 3'd0; end
        end
      end
    end
    n.lost = m.sync && !n.sync;
    return n;
  endfunction

  function automatic logic [3:0] model_state(input model_t m);
    if (m.sync)
      return (m.tier == 3'd1) ? 4'd6 : 4'(7 + 2 * (m.tier - 2) + ((m.good != 0) ? 1 : 0));
    if (m.acq == 2'd0) return 4'd0;
    return m.cd ? 4'(2 * m.acq - 1) : 4'(2 * m.acq);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = '0;
      m0 = '0;
    end else begin
      m1 = step(m1, 1'b1, bus1.cg_valid, bus1.cg_in, bus1.data_in, bus1.is_control_in,
                bus1.decode_error, bus1.disparity_error, sd);
      m0 = step(m0, 1'b0, bus0.cg_valid, bus0.cg_in, bus0.data_in, bus0.is_control_in,
                bus0.decode_error, bus0.disparity_error, sd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tag, input model_t m, input logic [3:0] st,
                         input logic ss, input logic re, input logic ls,
                         input logic ov, input logic [7:0] dat, input logic ctl);
    chk({tag, "_state"}, 32'(st), 32'(model_state(m)));
    chk({tag, "_sync_status"}, 32'(ss), 32'(m.sync));
    chk({tag, "_rx_even"}, 32'(re), 32'(m.even));
    chk({tag, "_lost_sync"}, 32'(ls), 32'(m.lost));
    chk({tag, "_out_valid"}, 32'(ov), 32'(m.ov));
    chk({tag, "_data_out"}, 32'(dat), 32'(m.dat));
    chk({tag, "_is_control_out"}, 32'(ctl), 32'(m.ctl));
  endtask

  always @(negedge clk) begin
    cmp_dut("d1", m1, st1, ss1, re1, ls1, bus1.out_valid, bus1.data_out, bus1.is_control_out);
    cmp_dut("d0", m0, st0, ss0, re0, ls0, bus0.out_valid, bus0.data_out, bus0.is_control_out);
  end

  task automatic set_in(input logic v, input logic [9:0] cg, input logic [7:0] d,
                        input logic k, input logic de, input logic pe);
    bus1.cg_valid = v; bus1.cg_in = cg; bus1.data_in = d;
    bus1.is_control_in = k; bus1.decode_error = de; bus1.disparity_error = pe;
    bus0.cg_valid = v; bus0.cg_in = cg; bus0.data_in = d;
    bus0.is_control_in = k; bus0.decode_error = de; bus0.disparity_error = pe;
  endtask

  // One accepted code-group; negative expectations are skipped.
  task automatic send(input logic [9:0] cg, input logic [7:0] d, input logic k, input logic de,
                      input int exp_st, input int exp_ss, input int exp_ls);
    set_in(1'b1, cg, d, k, de, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (exp_st >= 0) begin
      chk("lit_state", 32'(st1), exp_st);
      chk("lit_model_state", 32'(model_state(m1)), exp_st);
    end
    if (exp_ss >= 0) chk("lit_sync_status", 32'(ss1), exp_ss);
    if (exp_ls >= 0) chk("lit_lost_sync", 32'(ls1), exp_ls);
  endtask

  task automatic acquire();
    for (int i = 0; i < 3; i++) begin
      send((i == 1) ? K_P : K_N, 8'hBC, 1'b1, 1'b0, 2 * i + 1, 0, -1);
      chk("lit_rx_even_after_comma", 32'(re1), 1);
      send(D_P, 8'h50, 1'b0, 1'b0, 2 * i + 2, (i == 2) ? 1 : 0, -1);
    end
  endtask

  task automatic idle();
    set_in(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int p;
    set_in(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(st1), 0);
    chk("rst_sync_status", 32'(ss1), 0);
    chk("rst_rx_even", 32'(re1), 0);
    chk("rst_out_valid", 32'(bus1.out_valid), 0);
    chk("rst_data_out", 32'(bus1.data_out), 0);
    rst_n = 1'b1;

    // Comma in the odd position while in AS1.
    send(K_N, 8'hBC, 1'b1, 1'b0, 1, 0, -1);
    send(D_P, 8'h50, 1'b0, 1'b0, 2, 0, -1);
    send(D_P, 8'h50, 1'b0, 1'b0, 2, 0, -1);
    send(K_P, 8'hBC, 1'b1, 1'b0, 0, 0, 0);

    acquire();

    // Single error then four good groups returns to SA1.
    send(D_P, 8'h51, 1'b0, 1'b1, 7, 1, 0);
    send(D_P, 8'h52, 1'b0, 1'b0, 8, 1, 0);
    send(D_P, 8'h53, 1'b0, 1'b0, 8, 1, 0);
    send(D_P, 8'h54, 1'b0, 1'b0, 8, 1, 0);
    send(D_P, 8'h55, 1'b0, 1'b0, 6, 1, 0);

    // Four bad groups too close together.
    send(D_P, 8'h60, 1'b0, 1'b1, 7, 1, 0);
    send(D_P, 8'h61, 1'b0, 1'b0, 8, 1, 0);
    send(D_P, 8'h62, 1'b0, 1'b1, 9, 1, 0);
    send(D_P, 8'h63, 1'b0, 1'b0, 10, 1, 0);
    send(D_P, 8'h64, 1'b0, 1'b1, 11, 1, 0);
    send(D_P, 8'h65, 1'b0, 1'b1, 0, 0, 1);
    idle();
    chk("lit_lost_sync_pulse_end", 32'(ls1), 0);

    // signal_detect glitch while idle in SA2A.
    acquire();
    send(D_P, 8'h70, 1'b0, 1'b1, 7, 1, 0);
    send(D_P, 8'h71, 1'b0, 1'b0, 8, 1, 0);
    set_in(1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    sd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sd = 1'b1;
    chk("lit_sd_drop_state_en1", 32'(st1), 0);
    chk("lit_sd_drop_lost_en1", 32'(ls1), 1);
    chk("lit_sd_drop_state_en0", 32'(st0), 8);

    // Asynchronous reset in SA3A with a valid code-group present.
    acquire();
    send(D_P, 8'h80, 1'b0, 1'b1, 7, 1, -1);
    send(D_P, 8'h81, 1'b0, 1'b1, 9, 1, -1);
    send(D_P, 8'h82, 1'b0, 1'b0, 10, 1, -1);
    set_in(1'b1, D_P, 8'h83, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(st1), 0);
    chk("arst_sync_status", 32'(ss1), 0);
    chk("arst_rx_even", 32'(re1), 0);
    chk("arst_lost_sync", 32'(ls1), 0);
    chk("arst_out_valid", 32'(bus1.out_valid), 0);
    chk("arst_data_out", 32'(bus1.data_out), 0);
    chk("arst_is_control_out", 32'(bus1.is_control_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    acquire();

    // Random traffic, commas biased toward the even slot.
    p = 0;
    for (int i = 0; i < 4000; i++) begin
      logic v;
      logic [9:0] cg;
      logic [7:0] d;
      logic k;
      int r;
      v = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 19);
      if (r == 0) begin
        cg = 10'($urandom); d = 8'($urandom); k = 1'($urandom);
      end else if ((p == 0 && r < 6) || r == 19) begin
        cg = r[0] ? K_N : K_P; d = 8'hBC; k = 1'b1;
      end else if (r == 18) begin
        cg = K23; d = 8'hF7; k = 1'b1;
      end else begin
        cg = D_P; d = 8'($urandom); k = 1'b0;
      end
      set_in(v, cg, d, k, $urandom_range(0, 49) == 0, $urandom_range(0, 69) == 0);
      sd = ($urandom_range(0, 299) != 0);
      @(posedge clk);
      @(negedge clk);
      if (v) p ^= 1;
    end
    sd = 1'b1;
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_sync_fsm.md
PCS_SYNC_FSM -- requirements
Module: pcs_sync_fsm

Interface
REQ-001 SHALL have parameter SIGNAL_DETECT_EN, default 1, meaning 1 = honour signal_detect and 0 = treat signal_detect as permanently 1.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have cg_valid  input  1  qualifier: one code-group per cycle when high.
REQ-005 SHALL have cg_in  input  10  raw code-group as received, bit order abcdeifghj, bit9 = a.
REQ-006 SHALL have data_in  input  8  decoded byte HGFEDCBA from the 8B/10B decoder.
REQ-007 SHALL have is_control_in  input  1  decoder flag: 1 = K code-group.
REQ-008 SHALL have decode_error  input  1  decoder flag for an invalid code-group.
REQ-009 SHALL have disparity_error  input  1  decoder flag for a running-disparity error.
REQ-010 SHALL have signal_detect  input  1  PMD signal present.
REQ-011 SHALL have sync_status  output  1  1 = OK, 0 = FAIL.
REQ-012 SHALL have rx_even  output  1  parity of the last accepted code-group.
REQ-013 SHALL have sync_state  output  4  current state encoding.
REQ-014 SHALL have out_valid  output  1  registered copy of cg_valid.
REQ-015 SHALL have data_out  output  8  registered copy of data_in.
REQ-016 SHALL have is_control_out  output  1  registered copy of is_control_in.
REQ-017 SHALL have lost_sync  output  1  one-cycle pulse on any transition from sync_status = 1 to 0.

Function
REQ-018 SHALL define the following terms, all evaluated only when cg_valid = 1:
- comma = (cg_in[9:3] == 7'b0011111) or (cg_in[9:3] == 7'b1100000).
- invalid = decode_error or disparity_error.
- cgbad = invalid or (comma and rx_even == 1).
- cggood = not cgbad.
- isdata = not invalid and not is_control_in.
REQ-019 SHALL use these state encodings: LOSS_OF_SYNC=0, CD1=1, AS1=2, CD2=3, AS2=4, CD3=5, SA1=6, SA2=7, SA2A=8, SA3=9, SA3A=10, SA4=11, SA4A=12; values 13-15 SHALL go to LOSS_OF_SYNC on the next edge.
REQ-020 SHALL hold all state, rx_even and counters when cg_valid = 0, except for the signal_detect rule in REQ-021.
REQ-021 SHALL enter LOSS_OF_SYNC from any state on the next edge when signal_detect = 0 and SIGNAL_DETECT_EN = 1, regardless of cg_valid; this rule has priority over all other transitions.
REQ-022 SHALL toggle rx_even on each accepted code-group, except on entry to CD1, CD2 or CD3, where rx_even SHALL be forced to 1.
REQ-023 SHALL, in LOSS_OF_SYNC, go to CD1 on a comma; any other code-group SHALL stay in LOSS_OF_SYNC.
REQ-024 SHALL, in CDk (k = 1 to 3), go to ASk on isdata (SA1 when k = 3); otherwise it SHALL go to LOSS_OF_SYNC.
REQ-025 SHALL, in ASk (k = 1, 2), act as follows:
- cgbad: go to LOSS_OF_SYNC.
- comma with rx_even == 0: go to CD(k+1).
- otherwise: stay in ASk.
REQ-026 SHALL, in SA1, stay on cggood and go to SA2 on cgbad.
REQ-027 SHALL clear a 2-bit good_cnt to 0 on entry to SA2, SA3 or SA4.
REQ-028 SHALL, in SAk (k = 2 to 4), go to SAkA on cggood with good_cnt = 1; on cgbad it SHALL go to SA(k+1), or to LOSS_OF_SYNC when k = 4.
REQ-029 SHALL, in SAkA, act as follows:
- cggood with good_cnt < 3: increment good_cnt and stay.
- cggood with good_cnt == 3: go to SA(k-1) (SA1 when k = 2), i.e. after 4 consecutive good code-groups.
- cgbad: go to SA(k+1), or to LOSS_OF_SYNC when k = 4.
REQ-030 SHALL register sync_status as 1 exactly when the next state is SA1 through SA4A; sync_status and sync_state SHALL update on the same edge as the transition.
REQ-031 SHALL register data_out, is_control_out and out_valid with 1-cycle latency, unconditionally, independent of state.

Reset
REQ-032 SHALL, while rst_n = 0, drive sync_state = LOSS_OF_SYNC, sync_status = 0, rx_even = 0, good_cnt = 0, out_valid = 0, data_out = 8'h00, is_control_out = 0 and lost_sync = 0.
REQ-033 SHALL, when reset is asserted mid-operation, apply those values immediately; the first edge after release SHALL evaluate from LOSS_OF_SYNC.

Verification
REQ-034 SHALL cover acquisition: /K28.5/D16.2/ repeated 3 times after reset (comma 0011111010 / 1100000101) -> states 1,2,3,4,5,6; sync_status = 1 on the edge accepting the third D16.2; rx_even = 1 after each comma.
REQ-035 SHALL cover a comma in the odd position during AS1 (comma while rx_even = 1) -> LOSS_OF_SYNC; sync_status remains 0.
REQ-036 SHALL cover, in SA1, one decode_error followed by 4 good code-groups -> states 7, 8, 8, 8, 6; sync_status stays 1 and lost_sync = 0 throughout.
REQ-037 SHALL cover, in SA1, 4 cgbad spaced by fewer than 4 good code-groups each -> states 7, 9, 11, then LOSS_OF_SYNC; sync_status = 0 and lost_sync = 1 for exactly one cycle.
REQ-038 SHALL cover signal_detect dropped for 1 cycle with cg_valid = 0 in SA2A -> LOSS_OF_SYNC on the next edge; with SIGNAL_DETECT_EN = 0 the state SHALL be unaffected.
REQ-039 SHALL cover rst_n asserted in SA3A with cg_valid = 1 -> all outputs at reset values asynchronously; after release, re-acquisition SHALL follow the REQ-034 sequence.
